fetch_sequencer: RTL

Instruction-fetch controller for the 4-stage pipeline. Drives the 8-bit PC into the instruction memory and samples the returned instruction code into the IF/ID pipeline register. Resolves unconditional jumps at fetch with no bubble. Honours stall and redirect requests from later stages, and sequences a run from start to program end, including pipeline drain.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/fetch_sequencer_if.sv | 26 ++
 rtl/next_pc_logic.sv | 16 +
 rtl/fetch_sequencer.sv | 103 ++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants, opcodes and fetch-stage types.
// Used by the fetch sequencer, its next-PC logic and its interface.
package cpu_pkg;
    localparam int ADDR_W       = 8;
    localparam int INSTR_W      = 8;
    localparam int DRAIN_CYCLES = 3;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_J   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } fetch_state_t;

    typedef struct packed {
        logic               valid;
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } ifid_t;
endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus: run control, instruction-memory port, IF/ID register and status.
// master = the sequencer, slave = the surrounding pipeline / memory.
interface fetch_sequencer_if;
    logic                       start;
    logic [cpu_pkg::ADDR_W-1:0]  prog_len;
    logic [cpu_pkg::INSTR_W-1:0] instr_code;
    logic                       stall;
    logic                       redirect_valid;
    logic [cpu_pkg::ADDR_W-1:0]  redirect_pc;
    logic [cpu_pkg::ADDR_W-1:0]  pc;
    logic [cpu_pkg::INSTR_W-1:0] ifid_instr;
    logic [cpu_pkg::ADDR_W-1:0]  ifid_pc;
    logic                       ifid_valid;
    logic                       busy;
    logic                       done;

    modport master (
        input  start, prog_len, instr_code, stall, redirect_valid, redirect_pc,
        output pc, ifid_instr, ifid_pc, ifid_valid, busy, done
    );

    modport slave (
        output start, prog_len, instr_code, stall, redirect_valid, redirect_pc,
        input  pc, ifid_instr, ifid_pc, ifid_valid, busy, done
    );
endinterface

// File: rtl/next_pc_logic.sv
// Sequential / jump next-PC: pc+1, plus sign-extended 6-bit offset for OP_J.
// All arithmetic wraps modulo 2^ADDR_W.
module next_pc_logic
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  next_pc
);
    logic              is_jump;
    logic [ADDR_W-1:0] offset;

    assign is_jump = (instr[7:6] == OP_J);
    assign offset  = {{(ADDR_W-6){instr[5]}}, instr[5:0]};
    assign next_pc = pc + ADDR_W'(1) + (is_jump ? offset : '0);
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: drives pc, fills IF/ID, resolves jumps with no bubble,
// honours stall/redirect, and drains the pipeline after the last fetch.
module fetch_sequencer
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    fetch_sequencer_if.master  bus
);
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [DCW-1:0]    drain_q, drain_d;
    logic              done_q, done_d;
    ifid_t             ifid_q, ifid_d;
    logic [ADDR_W-1:0] seq_pc;

    next_pc_logic u_next_pc (
        .pc      (pc_q),
        .instr   (bus.instr_code),
        .next_pc (seq_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            len_q   <= '0;
            drain_q <= '0;
            done_q  <= 1'b0;
            ifid_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            len_q   <= len_d;
            drain_q <= drain_d;
            done_q  <= done_d;
            ifid_q  <= ifid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        drain_d = drain_q;
        done_d  = done_q;
        ifid_d  = ifid_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    len_d  = bus.prog_len;
                    pc_d   = '0;
                    done_d = 1'b0;
                    if (bus.prog_len == '0) begin
                        state_d = ST_DRAIN;
                        drain_d = DCW'(DRAIN_CYCLES - 1);
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                // Redirect outranks stall: the younger instruction is squashed anyway.
                if (bus.redirect_valid) begin
                    pc_d         = bus.redirect_pc;
                    ifid_d.valid = 1'b0;
                end else if (bus.stall) begin
                    pc_d = pc_q;
                end else if (pc_q >= len_q) begin
                    ifid_d.valid = 1'b0;
                    drain_d      = DCW'(DRAIN_CYCLES - 1);
                    state_d      = ST_DRAIN;
                end else begin
                    ifid_d = '{valid: 1'b1, pc: pc_q, instr: bus.instr_code};
                    pc_d   = seq_pc;
                end
            end
            ST_DRAIN: begin
                ifid_d.valid = 1'b0;
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.pc         = pc_q;
    assign bus.ifid_instr = ifid_q.instr;
    assign bus.ifid_pc    = ifid_q.pc;
    assign bus.ifid_valid = ifid_q.valid;
    assign bus.busy       = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign bus.done       = done_q;
endmodule
